uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
- Synthesizable core-side UART boot protocol engine, the parametrised successor to the simulation host bench.
- After reset it announces readiness with a request byte, receives a little-endian byte-length header, then receives the program image.
- It assembles the image into words and writes them into instruction memory, then sends a completion byte.
- It sits between uart_rx/uart_tx and the instruction-memory write port, and holds the core in reset until it finishes.

Parameters:
- SYNC_REQ, 8'h99, byte sent after reset to request the header
- SYNC_DONE, 8'haa, byte sent after the image is loaded
- LEN_BYTES, 4, header width in bytes (1..4), little-endian
- WORD_BYTES, 4, bytes per memory word (1..8), little-endian assembly
- ADDR_W, 12, word-address width of the memory write port
- MAX_WORDS, 4096, capacity in words; must be ≤ 2**ADDR_W

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  byte from uart_rx
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_ferr  in  1  uart_rx framing error, sampled with rx_valid
- tx_data  out  8  byte to uart_tx
- tx_start  out  1  one-cycle send strobe
- tx_busy  in  1  uart_tx busy
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_W  word address
- wr_data  out  8*WORD_BYTES  word data
- done  out  1  image loaded and SYNC_DONE sent; core may run
- err  out  1  sticky error

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low on rstn. Reset is legal mid-operation: every register returns to its reset value and the sequence restarts from SEND_REQ.
- Reset values: tx_data=0, tx_start=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0. The state machine resets to SEND_REQ, and the byte/word counters reset to 0.
- States: SEND_REQ → TX_WAIT → RX_LEN → RX_PROG → [RX_CSUM] → SEND_FIN → FIN_WAIT → DONE. ERR is reachable from any receive state.
- SEND_REQ: when tx_busy=0, drive tx_data=SYNC_REQ and tx_start=1 for exactly 1 cycle, then go to TX_WAIT.
- TX_WAIT: skip one cycle so uart_tx can raise busy, then wait for tx_busy=0, then go to RX_LEN.
- RX_LEN: each rx_valid shifts rx_data into len[8*k +: 8], with k = 0..LEN_BYTES-1. Bytes arriving before the header phase are ignored.
- Header checks, applied after the last header byte:
  - len=0 → go to SEND_FIN directly (preloaded-memory case).
  - ceil(len/WORD_BYTES) > MAX_WORDS → go to ERR.
  - otherwise → go to RX_PROG.
- RX_PROG word assembly: each byte fills wr_data slot (byte_cnt mod WORD_BYTES).
- RX_PROG writes: on the last byte of a word, or the last byte of the image, wr_en pulses for 1 cycle on the following cycle. wr_addr equals the word index starting at 0, and wr_addr increments after each write.
- Final partial word: unfilled upper bytes are zero.
- RX_PROG latency: one cycle from rx_valid of the completing byte to the wr_en pulse.
- SEND_FIN / FIN_WAIT: identical to SEND_REQ / TX_WAIT but send SYNC_DONE, then go to DONE.
- DONE: done=1. All further rx bytes are ignored, and the block stays in DONE until reset.
- ERR: err=1 and sticky. No writes, no tx, done stays 0. Entry conditions:
  - rx_valid with rx_ferr=1 in any receive state;
  - header overflow;
  - checksum mismatch.
- Simultaneous rx_valid and tx_busy are independent; the receiver never stalls, since each byte is consumed in the cycle it is strobed.

Optional Feature:
- Macro: UART_BOOT_CHECKSUM_EN.
- Defined:
  - Keep a running 8-bit XOR over all image bytes.
  - After the last image byte, enter RX_CSUM and receive 1 byte.
  - Equal → go to SEND_FIN. Different → go to ERR with no SYNC_DONE sent; words already written stay written.
  - len=0 still expects a checksum byte of 8'h00.
- Undefined: the RX_CSUM state and XOR register are absent, and the image is followed directly by SYNC_DONE.

Test Plan:
- Default parameters; send len=8 (08 00 00 00), then bytes 13 00 00 00 93 00 10 00 → tx 8'h99 first; wr_en at addr0 with 32'h00000013, then at addr1 with 32'h00100093; then tx 8'haa; done=1.
- len=0 → 8'h99, then 8'haa with no wr_en pulses; done=1.
- len=6, bytes 01..06 → addr0=32'h04030201, addr1=32'h00000605 (zero-padded), exactly 2 writes.
- MAX_WORDS=4; len=20 → err=1 after the 4th header byte; no writes, no 8'haa.
- Pulse rstn low mid-image after 3 of 8 bytes → outputs cleared; 8'h99 resent; a full reload then succeeds with addr starting at 0.
- UART_BOOT_CHECKSUM_EN defined; len=4, bytes 11 22 44 88, checksum FF → done=1. Same image with checksum 00 → err=1, no 8'haa.

Source files
------------

// File: rtl/uart_boot_loader.sv
// uart_boot_loader -- core-side UART boot protocol engine.
//
// After reset it sends SYNC_REQ, receives a little-endian LEN_BYTES-byte
// length header, then receives that many image bytes. It packs them
// little-endian into WORD_BYTES-wide words and writes each word to
// instruction memory. When the image is complete it sends SYNC_DONE and
// raises done, which releases the core from reset.
//
// Optional feature (macro UART_BOOT_CHECKSUM_EN): the image is followed by a
// one-byte XOR checksum. A mismatch ends in the sticky error state without
// sending SYNC_DONE.
//
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   rx_data/valid/ferr    byte stream from uart_rx (ferr sampled with valid)
//   tx_data/start         byte and one-cycle send strobe to uart_tx
//   tx_busy               uart_tx busy
//   wr_en/addr/data       instruction-memory write port (word addressed)
//   done                  image loaded and SYNC_DONE sent
//   err                   sticky error (framing, oversize header, checksum)
module uart_boot_loader #(
  parameter logic [7:0] SYNC_REQ   = 8'h99,
  parameter logic [7:0] SYNC_DONE  = 8'haa,
  parameter int         LEN_BYTES  = 4,
  parameter int         WORD_BYTES = 4,
  parameter int         ADDR_W     = 12,
  parameter int         MAX_WORDS  = 4096
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    rx_ferr,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_data,
  output logic                    done,
  output logic                    err
);

  localparam int LEN_W  = 8 * LEN_BYTES;
  localparam int DATA_W = 8 * WORD_BYTES;
  // ceil(len/WORD_BYTES) > MAX_WORDS is equivalent to len > MAX_WORDS*WORD_BYTES,
  // which avoids a divider and cannot overflow at this width.
  localparam logic [40:0]       MAX_LEN  = 41'(MAX_WORDS) * 41'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

  typedef enum logic [3:0] {
    SEND_REQ,
    TX_WAIT,
    RX_LEN,
    RX_PROG,
`ifdef UART_BOOT_CHECKSUM_EN
    RX_CSUM,
`endif
    SEND_FIN,
    FIN_WAIT,
    DONE,
    ERR
  } state_t;

  state_t              state_reg, state_next;
  logic                skip_reg, skip_next;
  logic [7:0]          tx_data_reg, tx_data_next;
  logic                tx_start_reg, tx_start_next;
  logic                wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
  logic [DATA_W-1:0]   word_reg, word_next, word_new;
  logic [LEN_W-1:0]    len_reg, len_next, len_new;
  logic [LEN_W-1:0]    byte_cnt_reg, byte_cnt_next;
  logic [2:0]          slot_reg, slot_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic                last_img;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]          csum_reg, csum_next;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= SEND_REQ;
      skip_reg     <= 1'b0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      word_reg     <= '0;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      slot_reg     <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_reg     <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      skip_reg     <= skip_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      word_reg     <= word_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      slot_reg     <= slot_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_reg     <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    skip_next     = skip_reg;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;
    wr_en_next    = 1'b0;
    // The address advances in the cycle after each write pulse.
    wr_addr_next  = wr_en_reg ? wr_addr_reg + ADDR_ONE : wr_addr_reg;
    wr_data_next  = wr_data_reg;
    word_next     = word_reg;
    word_new      = word_reg;
    len_next      = len_reg;
    len_new       = len_reg;
    byte_cnt_next = byte_cnt_reg;
    slot_next     = slot_reg;
    done_next     = done_reg;
    err_next      = err_reg;
    last_img      = 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
    csum_next     = csum_reg;
`endif

    case (state_reg)
      SEND_REQ, SEND_FIN: begin
        if (!tx_busy) begin
          tx_data_next  = (state_reg == SEND_REQ) ? SYNC_REQ : SYNC_DONE;
          tx_start_next = 1'b1;
          skip_next     = 1'b1;
          state_next    = (state_reg == SEND_REQ) ? TX_WAIT : FIN_WAIT;
        end
      end

      TX_WAIT, FIN_WAIT: begin
        // The first cycle is skipped so uart_tx has time to raise busy.
        if (skip_reg) begin
          skip_next = 1'b0;
        end else if (!tx_busy) begin
          if (state_reg == TX_WAIT) begin
            state_next    = RX_LEN;
            byte_cnt_next = '0;
          end else begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
      end

      RX_LEN: begin
        if (rx_valid) begin
          if (rx_ferr) begin
            state_next = ERR;
            err_next   = 1'b1;
          end else begin
            for (int i = 0; i < LEN_BYTES; i++) begin
              if (byte_cnt_reg == LEN_W'(i)) len_new[8*i +: 8] = rx_data;
            end
            len_next      = len_new;
            byte_cnt_next = byte_cnt_reg + LEN_ONE;
            if (byte_cnt_reg == LEN_W'(LEN_BYTES - 1)) begin
              byte_cnt_next = '0;
              slot_next     = '0;
              word_next     = '0;
              if (len_new == '0) begin
`ifdef UART_BOOT_CHECKSUM_EN
                state_next = RX_CSUM;
`else
                state_next = SEND_FIN;
`endif
              end else if (41'(len_new) > MAX_LEN) begin
                state_next = ERR;
                err_next   = 1'b1;
              end else begin
                state_next = RX_PROG;
              end
            end
          end
        end
      end

      RX_PROG: begin
        if (rx_valid) begin
          if (rx_ferr) begin
            state_next = ERR;
            err_next   = 1'b1;
          end else begin
            for (int i = 0; i < WORD_BYTES; i++) begin
              if (slot_reg == 3'(i)) word_new[8*i +: 8] = rx_data;
            end
            word_next     = word_new;
            slot_next     = slot_reg + 3'd1;
            byte_cnt_next = byte_cnt_reg + LEN_ONE;
            last_img      = (byte_cnt_reg == len_reg - LEN_ONE);
`ifdef UART_BOOT_CHECKSUM_EN
            csum_next     = csum_reg ^ rx_data;
`endif
            // A short final word keeps the zeros its buffer was cleared to.
            if (last_img || slot_reg == 3'(WORD_BYTES - 1)) begin
              wr_en_next   = 1'b1;
              wr_data_next = word_new;
              word_next    = '0;
              slot_next    = '0;
            end
            if (last_img) begin
`ifdef UART_BOOT_CHECKSUM_EN
              state_next = RX_CSUM;
`else
              state_next = SEND_FIN;
`endif
            end
          end
        end
      end

`ifdef UART_BOOT_CHECKSUM_EN
      RX_CSUM: begin
        if (rx_valid) begin
          if (rx_ferr || rx_data != csum_reg) begin
            state_next = ERR;
            err_next   = 1'b1;
          end else begin
            state_next = SEND_FIN;
          end
        end
      end
`endif

      DONE: ;
      ERR:  ;
      default: begin
        state_next = ERR;
        err_next   = 1'b1;
      end
    endcase
  end

  assign tx_data  = tx_data_reg;
  assign tx_start = tx_start_reg;
  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader. A second instance with MAX_WORDS=4
// shares the stimulus and is only examined in the oversize-header step.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ferr = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_data, s_tx_data;
  logic        tx_start, s_tx_start;
  logic        wr_en, s_wr_en;
  logic [11:0] wr_addr, s_wr_addr;
  logic [31:0] wr_data, s_wr_data;
  logic        done, s_done;
  logic        err, s_err;

  int checks = 0;
  int errors = 0;

  uart_boot_loader dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .err(err)
  );

  uart_boot_loader #(.MAX_WORDS(4)) dut_small (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .tx_data(s_tx_data), .tx_start(s_tx_start), .tx_busy(tx_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .done(s_done), .err(s_err)
  );

  always #5 clk = ~clk;

  // Simple uart_tx stand-in: busy for 6 cycles after each start strobe.
  logic [3:0] busy_cnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) busy_cnt <= 4'd0;
    else if (tx_start) busy_cnt <= 4'd6;
    else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
  end
  assign tx_busy = (busy_cnt != 4'd0);

  // Output monitors
  logic [11:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_q[$];
  int          s_wr_cnt = 0;
  int          s_fin_cnt = 0;
  always @(negedge clk) begin
    if (wr_en) begin
      wr_addr_q.push_back(wr_addr);
      wr_data_q.push_back(wr_data);
    end
    if (tx_start) tx_q.push_back(tx_data);
    if (s_wr_en) s_wr_cnt <= s_wr_cnt + 1;
    if (s_tx_start && s_tx_data == 8'haa) s_fin_cnt <= s_fin_cnt + 1;
  end

  int tx_rd = 0;
  int wbase = 0;
  int sbase = 0;
  int sfin = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic f);
    repeat (2) @(negedge clk);
    rx_data  = b;
    rx_ferr  = f;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    $display("rx byte %02h ferr=%0b", b, f);
  endtask

  task automatic send_header(input logic [31:0] len);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    tx_rd = tx_q.size();
    wbase = wr_addr_q.size();
  endtask

  task automatic expect_tx(input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    while (tx_q.size() <= tx_rd && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (tx_q.size() <= tx_rd) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      $display("tx byte %02h", tx_q[tx_rd]);
      check(tag, 64'(tx_q[tx_rd]), 64'(exp));
      tx_rd++;
    end
  endtask

  // Waits for the request byte and for the handshake to reach the header phase.
  task automatic start_session(input string tag);
    expect_tx(8'h99, tag);
    repeat (12) @(negedge clk);
    wbase = wr_addr_q.size();
  endtask

  task automatic send_csum(input logic [7:0] c);
`ifdef UART_BOOT_CHECKSUM_EN
    send_byte(c, 1'b0);
`else
    if (c === 8'hxx) $display("unused checksum");
`endif
  endtask

  task automatic load_t1_image(input string tag);
    send_header(32'd8);
    send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    check({tag, "_no_early_wr"}, 64'(wr_en), 64'd0);
    send_byte(8'h00, 1'b0);
    check({tag, "_wr_latency"}, 64'(wr_en), 64'd1);
    send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b0);
    send_csum(8'h90);
    expect_tx(8'haa, {tag, "_fin"});
    repeat (15) @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_wr_count"}, 64'(wr_addr_q.size() - wbase), 64'd2);
    check({tag, "_addr0"}, 64'(wr_addr_q[wbase]), 64'd0);
    check({tag, "_data0"}, 64'(wr_data_q[wbase]), 64'h00000013);
    check({tag, "_addr1"}, 64'(wr_addr_q[wbase+1]), 64'd1);
    check({tag, "_data1"}, 64'(wr_data_q[wbase+1]), 64'h00100093);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rstn = 1'b1;

    // Two-word image
    start_session("t1_req");
    load_t1_image("t1");

    // Zero length: no writes, straight to SYNC_DONE
    do_reset();
    start_session("t2_req");
    send_header(32'd0);
    send_csum(8'h00);
    expect_tx(8'haa, "t2_fin");
    repeat (15) @(negedge clk);
    check("t2_done", 64'(done), 64'd1);
    check("t2_wr_count", 64'(wr_addr_q.size() - wbase), 64'd0);

    // Six bytes: zero-padded final word
    do_reset();
    start_session("t3_req");
    send_header(32'd6);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    send_byte(8'h06, 1'b0);
    check("t3_last_wr_latency", 64'(wr_en), 64'd1);
    send_csum(8'h07);
    expect_tx(8'haa, "t3_fin");
    repeat (15) @(negedge clk);
    check("t3_done", 64'(done), 64'd1);
    check("t3_wr_count", 64'(wr_addr_q.size() - wbase), 64'd2);
    check("t3_data0", 64'(wr_data_q[wbase]), 64'h04030201);
    check("t3_addr1", 64'(wr_addr_q[wbase+1]), 64'd1);
    check("t3_data1", 64'(wr_data_q[wbase+1]), 64'h00000605);

    // Oversize header on the MAX_WORDS=4 instance (20 bytes > 16)
    do_reset();
    start_session("t4_req");
    sbase = s_wr_cnt;
    sfin  = s_fin_cnt;
    send_header(32'd20);
    check("t4_small_err", 64'(s_err), 64'd1);
    check("t4_big_err", 64'(err), 64'd0);
    repeat (30) @(negedge clk);
    check("t4_small_no_wr", 64'(s_wr_cnt - sbase), 64'd0);
    check("t4_small_no_fin", 64'(s_fin_cnt - sfin), 64'd0);
    check("t4_small_done", 64'(s_done), 64'd0);

    // Reset in the middle of the image, then a full reload
    do_reset();
    start_session("t5_req");
    send_header(32'd8);
    send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("t5_rst_tx_data", 64'(tx_data), 64'd0);
    check("t5_rst_wr_addr", 64'(wr_addr), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tx_rd = tx_q.size();
    start_session("t5_req_again");
    load_t1_image("t5");

    // Framing error during the header
    do_reset();
    start_session("t6_req");
    send_byte(8'h08, 1'b1);
    check("t6_err", 64'(err), 64'd1);
    repeat (30) @(negedge clk);
    check("t6_done", 64'(done), 64'd0);
    check("t6_no_tx", 64'(tx_q.size() - tx_rd), 64'd0);

`ifdef UART_BOOT_CHECKSUM_EN
    // Checksum match
    do_reset();
    start_session("c1_req");
    send_header(32'd4);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h44, 1'b0); send_byte(8'h88, 1'b0);
    check("c1_wr", 64'(wr_en), 64'd1);
    send_byte(8'hff, 1'b0);
    expect_tx(8'haa, "c1_fin");
    repeat (15) @(negedge clk);
    check("c1_done", 64'(done), 64'd1);
    check("c1_data0", 64'(wr_data_q[wbase]), 64'h88442211);

    // Checksum mismatch
    do_reset();
    start_session("c2_req");
    send_header(32'd4);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h44, 1'b0); send_byte(8'h88, 1'b0);
    send_byte(8'h00, 1'b0);
    check("c2_err", 64'(err), 64'd1);
    repeat (30) @(negedge clk);
    check("c2_no_fin", 64'(tx_q.size() - tx_rd), 64'd0);
    check("c2_done", 64'(done), 64'd0);
    check("c2_word_kept", 64'(wr_addr_q.size() - wbase), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
